// File: rtl/accel_task_loader.sv
// Purpose : unpacks a host task packet from a 32-bit word stream into the accelerator's
//           InexRecur/state preload write ports, then drives is_start until done_i.
// Latency : an accepted record word is written one cycle later; is_start rises two cycles
//           after the last accepted word.
// Backpressure: s_ready is low in FLUSH, RUN and ERR; words are accepted only when
//           s_valid && s_ready.
//
// Ports: clk/rst (sync, active-high); s_valid/s_ready/s_data word stream;
//        ran_we/ran_w_addr/ran_w_data for InexRecur and state regfiles;
//        is_start (run level), done_i (run finished), abort_i (soft abort / error clear),
//        busy (not idle), err (sticky packet error).
// Optional feature: define LOADER_CHECKSUM_EN to require an XOR trailer word after the
//        last record (CHK state); without it LOAD_ST goes straight to FLUSH.
module accel_task_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int IR_W   = 32,
    parameter int ST_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    output logic              ran_we_InexRecur,
    output logic [ADDR_W-1:0] ran_w_addr_InexRecur,
    output logic [IR_W-1:0]   ran_w_data_InexRecur,
    output logic              ran_we_state_external,
    output logic [ADDR_W-1:0] ran_w_addr_state_external,
    output logic [ST_W-1:0]   ran_w_data_state_external,
    output logic              is_start,
    input  logic              done_i,
    input  logic              abort_i,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IR,
        S_LOAD_ST,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_FLUSH,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [12:0] DEPTH_N = 13'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   last_q, last_d;      // N-1, index of the final record
    logic                we_ir_q, we_ir_d;
    logic [ADDR_W-1:0]   addr_ir_q, addr_ir_d;
    logic [IR_W-1:0]     data_ir_q, data_ir_d;
    logic                we_st_q, we_st_d;
    logic [ADDR_W-1:0]   addr_st_q, addr_st_d;
    logic [ST_W-1:0]     data_st_q, data_st_d;
    logic                is_start_q, is_start_d;
    logic                err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]         csum_q, csum_d;
`endif

    logic                accept;
    logic [12:0]         hdr_n;
    logic                hdr_ok;

    always_comb begin
        s_ready = (state_q == S_IDLE) || (state_q == S_LOAD_IR) || (state_q == S_LOAD_ST);
`ifdef LOADER_CHECKSUM_EN
        if (state_q == S_CHK) begin
            s_ready = 1'b1;
        end
`endif
    end

    assign accept = s_valid && s_ready;
    assign hdr_n  = s_data[12:0];
    assign hdr_ok = (s_data[31:24] == 8'hA5) && (hdr_n != 13'd0) && (hdr_n <= DEPTH_N);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        we_ir_d   = 1'b0;
        addr_ir_d = addr_ir_q;
        data_ir_d = data_ir_q;
        we_st_d   = 1'b0;
        addr_st_d = addr_st_q;
        data_st_d = data_st_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        state_d = S_LOAD_IR;
                        idx_d   = '0;
                        last_d  = ADDR_W'(hdr_n - 13'd1);
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_LOAD_IR: begin
                if (accept) begin
                    we_ir_d   = 1'b1;
                    addr_ir_d = idx_q;
                    data_ir_d = s_data[IR_W-1:0];
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ s_data;
`endif
                    state_d   = S_LOAD_ST;
                end
            end
            S_LOAD_ST: begin
                if (accept) begin
                    we_st_d   = 1'b1;
                    addr_st_d = idx_q;
                    data_st_d = s_data[ST_W-1:0];
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ 32'(s_data[ST_W-1:0]);
`endif
                    if (idx_q == last_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_FLUSH;
`endif
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_LOAD_IR;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (s_data == csum_q) ? S_FLUSH : S_ERR;
                end
            end
`endif
            // One idle cycle lets the final write pulse retire before is_start
            // flips the accelerator's state port over to internal use.
            S_FLUSH: state_d = S_RUN;
            S_RUN: begin
                if (done_i) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        // Abort drops any write being registered this cycle and keeps the
        // port address/data at their previous values.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            we_ir_d   = 1'b0;
            addr_ir_d = addr_ir_q;
            data_ir_d = data_ir_q;
            we_st_d   = 1'b0;
            addr_st_d = addr_st_q;
            data_st_d = data_st_q;
        end

        is_start_d = (state_d == S_RUN);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            we_ir_q    <= 1'b0;
            addr_ir_q  <= '0;
            data_ir_q  <= '0;
            we_st_q    <= 1'b0;
            addr_st_q  <= '0;
            data_st_q  <= '0;
            is_start_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            we_ir_q    <= we_ir_d;
            addr_ir_q  <= addr_ir_d;
            data_ir_q  <= data_ir_d;
            we_st_q    <= we_st_d;
            addr_st_q  <= addr_st_d;
            data_st_q  <= data_st_d;
            is_start_q <= is_start_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign ran_we_InexRecur          = we_ir_q;
    assign ran_w_addr_InexRecur      = addr_ir_q;
    assign ran_w_data_InexRecur      = data_ir_q;
    assign ran_we_state_external     = we_st_q;
    assign ran_w_addr_state_external = addr_st_q;
    assign ran_w_data_state_external = data_st_q;
    assign is_start                  = is_start_q;
    assign err                       = err_q;
    assign busy                      = (state_q != S_IDLE);

endmodule

// File: tb/tb_accel_task_loader.sv
// Purpose : directed self-checking bench for accel_task_loader.
// Latency : checks one-cycle write latency and is_start two cycles after the last word.
// Backpressure: drives s_valid with optional random gaps and waits (bounded) on s_ready.
module tb_accel_task_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        we_ir;
    logic [11:0] addr_ir;
    logic [31:0] data_ir;
    logic        we_st;
    logic [11:0] addr_st;
    logic [17:0] data_st;
    logic        is_start;
    logic        done_i;
    logic        abort_i;
    logic        busy;
    logic        err;

    accel_task_loader dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_valid                   (s_valid),
        .s_ready                   (s_ready),
        .s_data                    (s_data),
        .ran_we_InexRecur          (we_ir),
        .ran_w_addr_InexRecur      (addr_ir),
        .ran_w_data_InexRecur      (data_ir),
        .ran_we_state_external     (we_st),
        .ran_w_addr_state_external (addr_st),
        .ran_w_data_state_external (data_st),
        .is_start                  (is_start),
        .done_i                    (done_i),
        .abort_i                   (abort_i),
        .busy                      (busy),
        .err                       (err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          gap_max = 0;
    logic [31:0] tb_x;

    // Write-port observer, sampled mid-cycle.
    logic [31:0] ir_mem [0:4095];
    logic [17:0] st_mem [0:4095];
    int          ir_cnt = 0;
    int          st_cnt = 0;
    int          overlap = 0;
    logic [11:0] ir_log [$];
    logic [11:0] st_log [$];
    logic [11:0] ir_last;
    logic [11:0] st_last;

    always @(negedge clk) begin
        if (!rst) begin
            if (we_ir) begin
                ir_mem[addr_ir] = data_ir;
                ir_cnt++;
                ir_log.push_back(addr_ir);
                ir_last = addr_ir;
            end
            if (we_st) begin
                st_mem[addr_st] = data_st;
                st_cnt++;
                st_log.push_back(addr_st);
                st_last = addr_st;
            end
            if ((we_ir || we_st) && is_start) begin
                overlap++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int t;
        @(negedge clk);
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = w;
        t = 0;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            chk("send_ready_timeout", {31'd0, s_ready}, 32'd1);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] w);
        tb_x = 32'd0;
        send(w);
    endtask

    task automatic send_rec(input logic [31:0] ir, input logic [31:0] st);
        tb_x = tb_x ^ ir ^ (st & 32'h0003_FFFF);
        send(ir);
        send(st);
    endtask

    task automatic end_pkt();
`ifdef LOADER_CHECKSUM_EN
        send(tb_x);
`endif
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!is_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_start"}, {31'd0, is_start}, 32'd1);
        chk({tag, "_run_ready"}, {31'd0, s_ready}, 32'd0);
        done_i = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;
        @(negedge clk);
        chk({tag, "_done_start"}, {31'd0, is_start}, 32'd0);
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    endtask

    int c_ir;
    int c_st;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; done_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_start", {31'd0, is_start}, 32'd0);
        chk("rst_we", {30'd0, we_ir, we_st}, 32'd0);
        chk("rst_addr", {8'd0, addr_ir, addr_st}, 32'd0);
        rst = 1'b0;

        // ---- 1: two-record packet, exact timing
        send_hdr(32'hA500_0002);
        @(negedge clk);
        chk("t1_hdr_busy", {31'd0, busy}, 32'd1);
        chk("t1_hdr_we", {31'd0, we_ir}, 32'd0);
        tb_x = tb_x ^ 32'h1111_1111 ^ 32'h3;
        send(32'h1111_1111);
        @(negedge clk);
        chk("t1_ir0_we", {31'd0, we_ir}, 32'd1);
        chk("t1_ir0_addr", {20'd0, addr_ir}, 32'd0);
        chk("t1_ir0_data", data_ir, 32'h1111_1111);
        chk("t1_ir0_st_we", {31'd0, we_st}, 32'd0);
        send(32'h0000_0003);
        @(negedge clk);
        chk("t1_st0_we", {31'd0, we_st}, 32'd1);
        chk("t1_st0_data", {14'd0, data_st}, 32'd3);
        chk("t1_st0_ir_we", {31'd0, we_ir}, 32'd0);
        chk("t1_ir_hold", data_ir, 32'h1111_1111);
        send_rec(32'h2222_2222, 32'h0000_0004);
        @(negedge clk);
        chk("t1_st1_we", {31'd0, we_st}, 32'd1);
        chk("t1_st1_addr", {20'd0, addr_st}, 32'd1);
        chk("t1_st1_start", {31'd0, is_start}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("t1_chk_model", tb_x, 32'h3333_3334);
        send(32'h3333_3334);
        @(negedge clk);
`endif
        chk("t1_flush_start", {31'd0, is_start}, 32'd0);
        chk("t1_flush_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("t1_rise_start", {31'd0, is_start}, 32'd1);
        chk("t1_rise_we", {30'd0, we_ir, we_st}, 32'd0);
        chk("t1_st_hold", {20'd0, addr_st}, 32'd1);
        finish_run("t1");
        chk("t1_mem_ir0", ir_mem[0], 32'h1111_1111);
        chk("t1_mem_ir1", ir_mem[1], 32'h2222_2222);
        chk("t1_mem_st0", {14'd0, st_mem[0]}, 32'd3);
        chk("t1_mem_st1", {14'd0, st_mem[1]}, 32'd4);

        // ---- 2: bad magic, abort, then a normal packet
        c_ir = ir_cnt; c_st = st_cnt;
        send_hdr(32'h5A00_0001);
        @(negedge clk);
        chk("t2_err", {31'd0, err}, 32'd1);
        chk("t2_ready", {31'd0, s_ready}, 32'd0);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        chk("t2_done_ignored", {31'd0, err}, 32'd1);
        chk("t2_no_writes", ir_cnt - c_ir + st_cnt - c_st, 32'd0);
        do_abort();
        @(negedge clk);
        chk("t2_abort_err", {31'd0, err}, 32'd0);
        chk("t2_abort_busy", {31'd0, busy}, 32'd0);
        send_hdr(32'hA500_0001);
        send_rec(32'hDEAD_BEEF, 32'hFFFF_FFFF);
        end_pkt();
        finish_run("t2");
        chk("t2_mem_ir", ir_mem[0], 32'hDEAD_BEEF);
        chk("t2_mem_st", {14'd0, st_mem[0]}, 32'h0003_FFFF);

        // ---- 3: N = 0 and N = 4097 rejected, N = 4096 loads fully
        send_hdr(32'hA500_0000);
        @(negedge clk);
        chk("t3_n0_err", {31'd0, err}, 32'd1);
        do_abort();
        send_hdr(32'hA500_1001);
        @(negedge clk);
        chk("t3_n4097_err", {31'd0, err}, 32'd1);
        do_abort();
        c_ir = ir_cnt; c_st = st_cnt;
        send_hdr(32'hA500_1000);
        for (int i = 0; i < 4096; i++) begin
            send_rec(32'hA000_0000 | i, i + 1);
        end
        end_pkt();
        finish_run("t3");
        chk("t3_ir_cnt", ir_cnt - c_ir, 32'd4096);
        chk("t3_st_cnt", st_cnt - c_st, 32'd4096);
        chk("t3_ir_last", {20'd0, ir_last}, 32'hFFF);
        chk("t3_st_last", {20'd0, st_last}, 32'hFFF);
        chk("t3_mem_ir_fff", ir_mem[4095], 32'hA000_0FFF);
        chk("t3_mem_st_fff", {14'd0, st_mem[4095]}, 32'h0000_1000);
        chk("t3_mem_ir_0", ir_mem[0], 32'hA000_0000);

        // ---- 4: three records with random valid gaps
        ir_log.delete(); st_log.delete();
        gap_max = 3;
        send_hdr(32'hA500_0003);
        send_rec(32'h0101_0101, 32'h11);
        send_rec(32'h0202_0202, 32'h22);
        send_rec(32'h0303_0303, 32'h33);
        end_pkt();
        gap_max = 0;
        finish_run("t4");
        chk("t4_ir_n", ir_log.size(), 32'd3);
        chk("t4_st_n", st_log.size(), 32'd3);
        for (int i = 0; i < 3 && i < ir_log.size() && i < st_log.size(); i++) begin
            chk("t4_ir_order", {20'd0, ir_log[i]}, i);
            chk("t4_st_order", {20'd0, st_log[i]}, i);
        end
        chk("t4_mem_st2", {14'd0, st_mem[2]}, 32'h33);

        // ---- 5: abort with the ST word of record 1 on the bus
        send_hdr(32'hA500_0003);
        send_rec(32'h0A0A_0A0A, 32'h0B);
        send(32'h0C0C_0C0C);
        c_st = st_cnt;
        @(negedge clk);
        abort_i = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h0000_0055;
        @(posedge clk);
        #1 abort_i = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        chk("t5_we_st", {31'd0, we_st}, 32'd0);
        chk("t5_addr_st_held", {20'd0, addr_st}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t5_no_st1", st_cnt - c_st, 32'd0);
        chk("t5_no_start", {31'd0, is_start}, 32'd0);
        chk("t5_ir1_kept", ir_mem[1], 32'h0C0C_0C0C);

`ifdef LOADER_CHECKSUM_EN
        // ---- 6: trailer good then bit-flipped
        send_hdr(32'hA500_0001);
        send_rec(32'h1234_5678, 32'h0001_0001);
        send(tb_x);
        finish_run("t6_good");
        send_hdr(32'hA500_0001);
        send_rec(32'h1234_5678, 32'h0001_0001);
        send(tb_x ^ 32'h0000_0100);
        @(negedge clk);
        chk("t6_bad_err", {31'd0, err}, 32'd1);
        repeat (4) @(negedge clk);
        chk("t6_bad_no_start", {31'd0, is_start}, 32'd0);
        do_abort();
        @(negedge clk);
        chk("t6_abort_err", {31'd0, err}, 32'd0);
`endif

        chk("overlap_total", overlap, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
